// File: rtl/ssd_scan_scheduler.sv
// Eight-digit active-low seven-segment scanner with an anti-ghosting blank gap per slot.
// Arbitrates the display between live game status and a latched, multi-frame message overlay.
module ssd_scan_scheduler #(
  parameter int BLANK_CYCLES = 1000,
  parameter int DIGIT_CYCLES = 49000,
  parameter int MSG_FRAMES   = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  turns_left,
  input  logic [2:0]  ships_remaining,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_nibbles,
  input  logic [7:0]  msg_mask,
  output logic        msg_active,
  output logic [7:0]  anode,
  output logic [6:0]  ssdOut
);

  localparam int SLOT = BLANK_CYCLES + DIGIT_CYCLES;
  localparam int SW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int FW   = $clog2(MSG_FRAMES + 1);

  // Handshake: an overlay is accepted on the rising edge where msg_valid && msg_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, SHOW = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_q;
  logic [2:0]    digit_q;
  logic [FW-1:0] frame_q;
  logic [31:0]   nib_q;
  logic [7:0]    mask_q;
  logic          en_q;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    seg_q;
  logic          ready_q, ready_d;
  logic          active_q, active_d;

  logic          slot_last, wrap, hs;
  logic [3:0]    nib;
  logic          en;
  logic [4:0]    units, tens;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign slot_last = (slot_q == SW'(SLOT - 1));
  assign wrap      = slot_last && (digit_q == 3'd7);
  assign hs        = msg_valid && ready_q;
  assign units     = turns_left % 5'd10;
  assign tens      = turns_left / 5'd10;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = PEND;
      PEND:    if (wrap) state_d = SHOW;
      SHOW:    if (wrap && (frame_q == FW'(MSG_FRAMES - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs, registered from the upcoming state so they track the edge exactly
  always_comb begin
    ready_d  = (state_d == IDLE);
    active_d = (state_d == SHOW);
  end

  // Content source for the current digit; only consumed at the start of a slot.
  always_comb begin
    nib = 4'h0;
    en  = 1'b0;
    if (state_q == SHOW) begin
      nib = nib_q[{digit_q, 2'b00} +: 4];
      en  = mask_q[digit_q];
    end else begin
      case (digit_q)
        3'd0:    begin nib = units[3:0]; en = 1'b1; end
        3'd1:    begin nib = tens[3:0];  en = (turns_left >= 5'd10); end
        3'd4:    begin nib = {1'b0, ships_remaining}; en = 1'b1; end
        default: begin nib = 4'h0; en = 1'b0; end
      endcase
    end
  end

  always_comb begin
    if ((slot_q < SW'(BLANK_CYCLES)) || !en_q) anode_d = 8'hFF;
    else                                       anode_d = ~(8'd1 << digit_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q   <= '0;
      digit_q  <= '0;
      frame_q  <= '0;
      nib_q    <= '0;
      mask_q   <= '0;
      en_q     <= 1'b0;
      anode_q  <= 8'hFF;
      seg_q    <= 7'h7F;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      slot_q <= slot_last ? '0 : slot_q + 1'b1;
      if (slot_last) digit_q <= digit_q + 1'b1;
      if (state_q == IDLE && hs) begin
        nib_q  <= msg_nibbles;
        mask_q <= msg_mask;
      end
      if (state_q == PEND && wrap)      frame_q <= '0;
      else if (state_q == SHOW && wrap) frame_q <= frame_q + 1'b1;
      // Segments settle during the blank gap and stay fixed for the slot.
      if (slot_q == '0) begin
        en_q  <= en;
        seg_q <= hex7(nib);
      end
      anode_q  <= anode_d;
      ready_q  <= ready_d;
      active_q <= active_d;
    end
  end

  assign anode      = anode_q;
  assign ssdOut     = seg_q;
  assign msg_ready  = ready_q;
  assign msg_active = active_q;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler: a frame-position reference model checked every cycle,
// directed literal expectations for the documented scenarios, then randomized traffic.
module tb_ssd_scan_scheduler;

  localparam int B  = 2;
  localparam int D  = 4;
  localparam int MF = 2;
  localparam int S  = B + D;
  localparam int F  = 8 * S;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  turns_left = 5'd0;
  logic [2:0]  ships_remaining = 3'd0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] msg_nibbles = 32'h0;
  logic [7:0]  msg_mask = 8'h0;
  logic        msg_active;
  logic [7:0]  anode;
  logic [6:0]  ssdOut;

  ssd_scan_scheduler #(.BLANK_CYCLES(B), .DIGIT_CYCLES(D), .MSG_FRAMES(MF)) dut (
    .clk(clk), .reset(reset), .turns_left(turns_left), .ships_remaining(ships_remaining),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_nibbles(msg_nibbles),
    .msg_mask(msg_mask), .msg_active(msg_active), .anode(anode), .ssdOut(ssdOut)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: scan position is simply cycles-since-reset modulo one frame
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit         m_live = 0;
  int         m_k, m_mode, m_fc, m_pos, m_dig, m_nibv;
  bit         m_wrap, m_en, m_hs, m_env;
  logic [31:0] m_nib;
  logic [7:0]  m_mask;
  logic [6:0]  m_seg;
  logic [7:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_seg_chk, e_ready, e_active;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_k = 0; m_mode = 0; m_fc = 0; m_en = 0;
      e_anode = 8'hFF; e_seg = 7'h7F; e_seg_chk = 1; e_ready = 0; e_active = 0;
    end else if (m_live) begin
      m_pos  = m_k % S;
      m_dig  = m_k / S;
      m_wrap = (m_k == F - 1);
      if (m_pos == 0) begin
        if (m_mode == 2) begin
          m_nibv = int'((m_nib >> (4 * m_dig)) & 32'hF);
          m_env  = m_mask[m_dig];
        end else begin
          m_nibv = 0; m_env = 0;
          if (m_dig == 0) begin m_nibv = int'(turns_left) % 10; m_env = 1; end
          if (m_dig == 1) begin m_nibv = int'(turns_left) / 10; m_env = (turns_left >= 10); end
          if (m_dig == 4) begin m_nibv = int'(ships_remaining); m_env = 1; end
        end
        m_en  = m_env;
        m_seg = seg_tab[m_nibv];
      end
      e_anode   = (m_pos < B || !m_en) ? 8'hFF : ~(8'h01 << m_dig);
      e_seg     = m_seg;
      e_seg_chk = m_en;
      m_hs = msg_valid && e_ready;
      if (m_mode == 0 && m_hs) begin
        m_mode = 1; m_nib = msg_nibbles; m_mask = msg_mask;
      end else if (m_mode == 1 && m_wrap) begin
        m_mode = 2; m_fc = 0;
      end else if (m_mode == 2 && m_wrap) begin
        m_fc++;
        if (m_fc == MF) m_mode = 0;
      end
      e_ready  = (m_mode == 0);
      e_active = (m_mode == 2);
      m_k = (m_k + 1) % F;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      check("anode", anode, e_anode);
      check("msg_ready", msg_ready, e_ready);
      check("msg_active", msg_active, e_active);
      if (e_seg_chk) check("ssdOut", ssdOut, e_seg);
    end
  end

  // driver tasks
  int cyc;
  logic [7:0] an_log [64];
  logic [6:0] sg_log [64];
  logic       rd_log [64];

  task automatic nxt();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_anode"}, anode, 8'hFF);
    check({tag, "_seg"}, ssdOut, 7'h7F);
    check({tag, "_ready"}, msg_ready, 1'b0);
    check({tag, "_active"}, msg_active, 1'b0);
  endtask

  task automatic log_frame();
    for (int c = 1; c < F; c++) begin
      nxt();
      an_log[c] = anode; sg_log[c] = ssdOut; rd_log[c] = msg_ready;
    end
  endtask

  int n;

  initial begin
    // status frame with turns_left=25, ships_remaining=3
    turns_left = 5'd25; ships_remaining = 3'd3;
    do_reset(3);
    check_reset_vals("rst0");
    log_frame();
    check("ready_rise", rd_log[1], 1'b1);
    check("s0_blank", an_log[2], 8'hFF);
    check("s0_anode", an_log[3], 8'hFE);
    check("s0_seg", sg_log[3], 7'b0010010);
    check("s1_blank", an_log[8], 8'hFF);
    check("s1_anode", an_log[9], 8'hFD);
    check("s1_seg", sg_log[9], 7'b0100100);
    check("s2_off", an_log[15], 8'hFF);
    check("s3_off", an_log[21], 8'hFF);
    check("s4_anode", an_log[27], 8'hEF);
    check("s4_seg", sg_log[27], 7'b0110000);
    check("s5_off", an_log[33], 8'hFF);
    check("s7_off", an_log[45], 8'hFF);

    // single-digit turns count blanks the tens digit
    turns_left = 5'd7;
    do_reset(2);
    log_frame();
    check("t7_s0_anode", an_log[3], 8'hFE);
    check("t7_s0_seg", sg_log[3], 7'b1111000);
    check("t7_s1_off", an_log[9], 8'hFF);

    // mid-frame overlay request
    turns_left = 5'd25;
    do_reset(2);
    while (cyc < 10) nxt();
    msg_valid = 1'b1; msg_nibbles = 32'h0000_0B1E; msg_mask = 8'h07;
    nxt();
    msg_valid = 1'b0; msg_nibbles = 32'hFFFF_FFFF; msg_mask = 8'hFF;
    check("hs_ready_drop", msg_ready, 1'b0);
    n = 0;
    while (!msg_active && n < 200) begin nxt(); n++; end
    check("ovl_start_cycle", cyc, F);
    while (cyc < F + 3) nxt();
    check("ovl_d0_anode", anode, 8'hFE);
    check("ovl_d0_seg", ssdOut, 7'b0000110);
    while (cyc < F + 9) nxt();
    check("ovl_d1_seg", ssdOut, 7'b1111001);
    while (cyc < F + 15) nxt();
    check("ovl_d2_anode", anode, 8'hFB);
    check("ovl_d2_seg", ssdOut, 7'b0000011);
    while (cyc < F + 21) nxt();
    check("ovl_d3_off", anode, 8'hFF);
    n = cyc - F;
    while (msg_active && n < 300) begin nxt(); n++; end
    check("ovl_len", n, MF * F);
    check("ovl_ready_back", msg_ready, 1'b1);

    // handshake on the frame-wrap cycle waits a full frame
    do_reset(2);
    while (cyc < F - 1) nxt();
    msg_valid = 1'b1; msg_nibbles = 32'h1234_5678; msg_mask = 8'hFF;
    nxt();
    msg_valid = 1'b0;
    check("wrap_ready_drop", msg_ready, 1'b0);
    n = 0;
    while (!msg_active && n < 200) begin nxt(); n++; end
    check("wrap_pend_len", n, F);

    // valid held through SHOW with churning payload; second accept on first ready cycle
    msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 300) begin
      msg_nibbles = $urandom; msg_mask = 8'($urandom);
      nxt(); n++;
    end
    check("second_accept_cycle", cyc, 4 * F);
    nxt();
    check("second_accept_drop", msg_ready, 1'b0);
    msg_valid = 1'b0;

    // reset in the middle of the overlay
    n = 0;
    while (!msg_active && n < 200) begin nxt(); n++; end
    repeat (10) nxt();
    do_reset(1);
    check_reset_vals("rst_show");
    while (cyc < 3) nxt();
    check("post_rst_anode", anode, 8'hFE);
    check("post_rst_seg", ssdOut, 7'b0010010);
    check("post_rst_active", msg_active, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) turns_left = 5'($urandom);
      if ($urandom_range(0, 15) == 0) ships_remaining = 3'($urandom);
      msg_valid   = ($urandom_range(0, 7) == 0);
      msg_nibbles = $urandom;
      msg_mask    = 8'($urandom);
      reset       = ($urandom_range(0, 599) == 0);
      nxt();
    end
    reset = 1'b0;
    msg_valid = 1'b0;
    nxt();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
